// File: rtl/parity_tx_pkg.sv
// parity_tx_pkg: shared state encoding and line levels for the parity serial transmitter.
// Contents: 3-bit state codes, state_t enum built on them, and the IDLE/START/STOP line levels.
package parity_tx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/parity_serial_tx_bit_timer.sv
// bit_timer: bit-period counter producing a one-cycle tick every CLKS_PER_BIT cycles.
// Ports: clk, rst (async, active-high), clear (restart period at 0), tick (terminal count).
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // With CLKS_PER_BIT=1 the counter sits at 0 and ticks every cycle.
    assign tick = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/parity_serial_tx.sv
// parity_serial_tx: serial transmitter sending start, DATA_W data bits LSB first, parity, stop.
// Ports: clk, rst (async, active-high), in_data/in_valid/in_ready (accept handshake),
//        tx (serial line, idles high), busy (frame in progress), parity_out (latched parity).
// Build option: define ODD_PARITY_EN for odd parity; default is even parity.
module parity_serial_tx
    import parity_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              parity_out
);

    localparam int IW = $clog2(DATA_W) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

    state_t            state, state_d;
    logic [DATA_W-1:0] shift, shift_d;
    logic [IW-1:0]     idx, idx_d;
    logic              par_d, tx_d, tick, clear, accept, word_par;

`ifdef ODD_PARITY_EN
    assign word_par = ~^in_data;
`else
    assign word_par = ^in_data;
`endif

    // in_ready is a flop that is only high in IDLE, so accept never fires mid-frame.
    assign accept = in_valid && in_ready;
    assign busy   = (state != IDLE);
    assign clear  = accept || (state_d != state);

    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .tick (tick)
    );

    always_comb begin
        state_d = state;
        shift_d = shift;
        idx_d   = idx;
        par_d   = parity_out;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    shift_d = in_data;
                    idx_d   = '0;
                    par_d   = word_par;
                end
            end
            START:  state_d = tick ? DATA : START;
            DATA: begin
                if (tick) begin
                    shift_d = shift >> 1;
                    idx_d   = idx + 1'b1;
                    state_d = (idx == LAST_IDX) ? PARITY : DATA;
                end
            end
            PARITY: state_d = tick ? STOP : PARITY;
            STOP:   state_d = tick ? IDLE : STOP;
            default: state_d = IDLE;
        endcase
        // tx is registered from the next state so the line changes with the state.
        tx_d = (state_d == START)  ? START_LEVEL :
               (state_d == DATA)   ? shift_d[0]  :
               (state_d == PARITY) ? par_d       :
               (state_d == STOP)   ? STOP_LEVEL  : IDLE_LEVEL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift      <= '0;
            idx        <= '0;
            parity_out <= 1'b0;
            tx         <= IDLE_LEVEL;
            in_ready   <= 1'b0;
        end else begin
            state      <= state_d;
            shift      <= shift_d;
            idx        <= idx_d;
            parity_out <= par_d;
            tx         <= tx_d;
            in_ready   <= (state_d == IDLE);
        end
    end

endmodule
